// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator with a shared period counter and
// shadow-buffered period/duty registers. Shadow values move to the active set
// only at a period boundary (or continuously while stopped), so a running
// waveform never sees a half-updated configuration.
//
// Build option: define PWM_CENTER_ALIGN_EN to compile in centre-aligned
// (up/down) counting selected by ctr_mode. Without it the block is
// edge-aligned only and ctr_mode is ignored.
module pwm_multi_ch #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16
) (
  input  logic                        chosen_clk,
  input  logic                        rst_n,
  input  logic                        pwm_en,
  input  logic                        upd_lock,
  input  logic                        ctr_mode,
  input  logic                        cfg_we,
  input  logic [$clog2(CH_NUM+1)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]            cfg_wdata,
  output logic [CH_NUM-1:0]           pwm,
  output logic                        period_done,
  output logic [CNT_W-1:0]            cnt_o
);

  localparam int AW = $clog2(CH_NUM+1);

  // Configuration: shadow set written by software, active set used by the counter
  logic [CNT_W-1:0]             per_sh;
  logic [CNT_W-1:0]             per_act;
  logic [CH_NUM-1:0][CNT_W-1:0] duty_sh;
  logic [CH_NUM-1:0][CNT_W-1:0] duty_act;

  // Counter stage (p0) and registered output stage (p1)
  logic [CNT_W-1:0]  cnt_p0;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CH_NUM-1:0] pwm_p1;
  logic [CH_NUM-1:0] pwm_nxt;
  logic              pd_p1;

  logic              run;
  logic              boundary;
  logic              xfer;
  logic [CNT_W-1:0]  per_last;

`ifdef PWM_CENTER_ALIGN_EN
  // dir_p0: 0 = counting up, 1 = counting down; mode_p0: 1 = centre-aligned
  logic dir_p0;
  logic dir_nxt;
  logic mode_p0;
  logic mode_nxt;
`else
  logic unused_ctr_mode;
  assign unused_ctr_mode = ctr_mode;
`endif

  // Unsigned duty compare: the output is high while the counter is below the duty
  function automatic logic duty_hit(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] d);
    return (c < d);
  endfunction

  // A zero period behaves like a stopped generator: counter parked, outputs low
  assign run      = pwm_en && (per_act != '0);
  assign per_last = per_act - 1'b1;

  // Next counter value and period-boundary detection
  always_comb begin
    cnt_nxt  = '0;
    boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_nxt  = 1'b0;
`endif
    if (run) begin
`ifdef PWM_CENTER_ALIGN_EN
      if (mode_p0) begin
        if (!dir_p0) begin
          if (cnt_p0 == per_last) begin
            // Peak: repeat P-1 once, then start down
            cnt_nxt = cnt_p0;
            dir_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_p0 + 1'b1;
          end
        end else if (cnt_p0 == '0) begin
          // Valley: repeat 0 once and turn up; this is the period boundary
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt_p0 - 1'b1;
          dir_nxt = 1'b1;
        end
      end else if (cnt_p0 == per_last) begin
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt_p0 + 1'b1;
      end
`else
      if (cnt_p0 == per_last) begin
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt_p0 + 1'b1;
      end
`endif
    end
  end

  // While stopped (or P=0) the active set tracks the shadow every edge so a new
  // period is picked up; while running it only moves at an unlocked boundary
  assign xfer = !run || (boundary && !upd_lock);

`ifdef PWM_CENTER_ALIGN_EN
  // Counting mode may only change where a period starts from 0
  assign mode_nxt = (!run || boundary) ? ctr_mode : mode_p0;
`endif

  // Per-channel compare against the pre-edge counter value
  always_comb begin
    pwm_nxt = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      pwm_nxt[k] = run && duty_hit(cnt_p0, duty_act[k]);
    end
  end

  // Shadow register writes; addresses above CH_NUM fall through untouched
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      per_sh  <= '0;
      duty_sh <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == '0) begin
        per_sh <= cfg_wdata;
      end
      for (int k = 0; k < CH_NUM; k++) begin
        if (cfg_addr == AW'(k + 1)) begin
          duty_sh[k] <= cfg_wdata;
        end
      end
    end
  end

  // Shadow-to-active transfer; a same-edge write lands in the shadow only
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      per_act  <= '0;
      duty_act <= '0;
    end else if (xfer) begin
      per_act  <= per_sh;
      duty_act <= duty_sh;
    end
  end

  // ---- stage p0 -> p1: counter advance and registered outputs ----
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
      pwm_p1 <= '0;
      pd_p1  <= 1'b0;
    end else begin
      cnt_p0 <= cnt_nxt;
      pwm_p1 <= pwm_nxt;
      pd_p1  <= boundary;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  // Count direction and the mode latched for the current period
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_p0  <= 1'b0;
      mode_p0 <= 1'b0;
    end else begin
      dir_p0  <= dir_nxt;
      mode_p0 <= mode_nxt;
    end
  end
`endif

  assign pwm         = pwm_p1;
  assign period_done = pd_p1;
  assign cnt_o       = cnt_p0;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: self-checking bench for pwm_multi_ch. A phase-based
// reference model (position within the current period) predicts pwm,
// period_done and cnt_o every cycle; table vectors and short directed
// sequences check high times and boundary behaviour with fixed expectations.
module tb_pwm_multi_ch;

  localparam int CH_NUM = 4;
  localparam int CNT_W  = 16;

  logic              chosen_clk = 1'b0;
  logic              rst_n;
  logic              pwm_en;
  logic              upd_lock;
  logic              ctr_mode;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [CNT_W-1:0]  cfg_wdata;
  logic [CH_NUM-1:0] pwm;
  logic              period_done;
  logic [CNT_W-1:0]  cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int p;
    int d0;
    int d1;
    int hi0;
    int hi1;
    int pd;
  } vec_t;

  pwm_multi_ch #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
    .chosen_clk  (chosen_clk),
    .rst_n       (rst_n),
    .pwm_en      (pwm_en),
    .upd_lock    (upd_lock),
    .ctr_mode    (ctr_mode),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .pwm         (pwm),
    .period_done (period_done),
    .cnt_o       (cnt_o)
  );

  always #5 chosen_clk = ~chosen_clk;

  // Reference model state: shadow/active config plus phase within the period
  int          m_sh_p;
  int          m_p;
  int          m_ph;
  int          m_sh_d[CH_NUM];
  int          m_d[CH_NUM];
  logic        m_mode;
  logic [CH_NUM-1:0] m_pwm;
  logic        m_pd;

  // Counter value implied by the phase: straight ramp, or ramp then mirror
  function automatic int m_cnt();
    if (m_mode && m_ph >= m_p) return 2 * m_p - 1 - m_ph;
    return m_ph;
  endfunction

  task automatic model_reset();
    m_sh_p = 0;
    m_p    = 0;
    m_ph   = 0;
    m_mode = 1'b0;
    m_pwm  = '0;
    m_pd   = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      m_sh_d[i] = 0;
      m_d[i]    = 0;
    end
  endtask

  task automatic model_step();
    int old_p;
    int old_d[CH_NUM];
    int len;
    int c;
    bit bnd;
    bit xf;
    old_p = m_sh_p;
    for (int i = 0; i < CH_NUM; i++) old_d[i] = m_sh_d[i];
    if (cfg_we) begin
      if (cfg_addr == 3'd0) m_sh_p = int'(cfg_wdata);
      else if (int'(cfg_addr) <= CH_NUM) m_sh_d[int'(cfg_addr) - 1] = int'(cfg_wdata);
    end
    if (!pwm_en || m_p == 0) begin
      m_ph  = 0;
      m_pwm = '0;
      m_pd  = 1'b0;
      xf    = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
      m_mode = ctr_mode;
`endif
    end else begin
      len = m_mode ? 2 * m_p : m_p;
      c   = m_cnt();
      for (int i = 0; i < CH_NUM; i++) m_pwm[i] = (c < m_d[i]);
      bnd  = (m_ph == len - 1);
      m_pd = bnd;
      m_ph = bnd ? 0 : m_ph + 1;
      xf   = bnd && !upd_lock;
`ifdef PWM_CENTER_ALIGN_EN
      if (bnd) m_mode = ctr_mode;
`endif
    end
    if (xf) begin
      m_p = old_p;
      for (int i = 0; i < CH_NUM; i++) m_d[i] = old_d[i];
    end
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later
  task automatic tick();
    @(posedge chosen_clk);
    model_step();
    #1;
    n_tests++;
    if (pwm !== m_pwm || period_done !== m_pd || cnt_o !== CNT_W'(m_cnt())) begin
      n_fail++;
      $display("FAIL cycle t=%0t: pwm=%b pd=%b cnt=%0d, required pwm=%b pd=%b cnt=%0d",
               $time, pwm, period_done, cnt_o, m_pwm, m_pd, m_cnt());
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic wr_tick(input int addr, input int data);
    logic [31:0] a;
    logic [31:0] d;
    a         = addr;
    d         = data;
    cfg_we    = 1'b1;
    cfg_addr  = a[2:0];
    cfg_wdata = d[CNT_W-1:0];
    tick();
    cfg_we    = 1'b0;
  endtask

  // Load period and duties while stopped; the extra edge moves them to active
  task automatic setup(input int p, input int d0, input int d1, input int d2, input int d3);
    pwm_en = 1'b0;
    wr_tick(0, p);
    wr_tick(1, d0);
    wr_tick(2, d1);
    wr_tick(3, d2);
    wr_tick(4, d3);
    tick();
  endtask

  task automatic run(input int n, output int h0, output int h1, output int h2,
                     output int h3, output int pc);
    h0 = 0; h1 = 0; h2 = 0; h3 = 0; pc = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      h2 += int'(pwm[2]);
      h3 += int'(pwm[3]);
      pc += int'(period_done);
    end
  endtask

  task automatic wait_cnt(input int v, input string nm);
    int k;
    k = 0;
    while (cnt_o != CNT_W'(v) && k < 100) begin
      tick();
      k++;
    end
    check(nm, int'(cnt_o), v);
  endtask

  task automatic wait_pd(input string nm);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (period_done != 1'b1 && k < 100);
    check(nm, int'(period_done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int h0, h1, h2, h3, pc, w;
`ifdef PWM_CENTER_ALIGN_EN
    int cseq[8];
`endif

    rst_n     = 1'b0;
    pwm_en    = 1'b0;
    upd_lock  = 1'b0;
    ctr_mode  = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    model_reset();

    // {P, D0, D1, high0 over window, high1 over window, period_done count}
    // window = 3*P cycles (12 when P=0)
    vt[0] = '{10, 3,  0,     9,  0, 3};
    vt[1] = '{10, 10, 15,    30, 30, 3};
    vt[2] = '{5,  1,  4,     3,  12, 3};
    vt[3] = '{1,  1,  0,     3,  0,  3};
    vt[4] = '{7,  6,  7,     18, 21, 3};
    vt[5] = '{0,  5,  5,     0,  0,  0};
    vt[6] = '{3,  2,  65535, 6,  9,  3};
    vt[7] = '{2,  0,  1,     0,  3,  3};

    #3;
    check("reset_pwm", int'(pwm), 0);
    check("reset_pd", int'(period_done), 0);
    check("reset_cnt", int'(cnt_o), 0);
    #9 rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      setup(vt[v].p, vt[v].d0, vt[v].d1, 0, 0);
      pwm_en = 1'b1;
      w = (vt[v].p == 0) ? 12 : 3 * vt[v].p;
      run(w, h0, h1, h2, h3, pc);
      check($sformatf("vec%0d_hi0", v), h0, vt[v].hi0);
      check($sformatf("vec%0d_hi1", v), h1, vt[v].hi1);
      check($sformatf("vec%0d_pd", v), pc, vt[v].pd);
    end

    // Basic four-channel pattern
    setup(10, 3, 0, 10, 15);
    pwm_en = 1'b1;
    run(30, h0, h1, h2, h3, pc);
    check("basic_ch0", h0, 9);
    check("basic_ch1", h1, 0);
    check("basic_ch2", h2, 30);
    check("basic_ch3", h3, 30);
    check("basic_pd", pc, 3);

    // Duty write mid-period takes effect only from the next period
    wait_cnt(4, "shadow_reach4");
    wr_tick(1, 7);
    run(5, h0, h1, h2, h3, pc);
    check("shadow_cur_period", h0, 0);
    run(10, h0, h1, h2, h3, pc);
    check("shadow_next_period", h0, 7);
    run(9, h0, h1, h2, h3, pc);
    check("late_at_cnt9", int'(cnt_o), 9);
    wr_tick(1, 2);
    run(10, h0, h1, h2, h3, pc);
    check("late_write_same", h0, 7);
    run(10, h0, h1, h2, h3, pc);
    check("late_write_next", h0, 2);

    // Update lock holds the old configuration across boundaries
    setup(10, 3, 0, 0, 0);
    pwm_en   = 1'b1;
    upd_lock = 1'b1;
    wr_tick(0, 20);
    wr_tick(1, 15);
    wait_cnt(0, "lock_align");
    run(30, h0, h1, h2, h3, pc);
    check("lock_hold_hi", h0, 9);
    check("lock_hold_pd", pc, 3);
    upd_lock = 1'b0;
    wait_pd("unlock_boundary");
    run(20, h0, h1, h2, h3, pc);
    check("unlock_hi", h0, 15);
    check("unlock_pd", pc, 1);

    // Mid-period asynchronous reset
    setup(10, 5, 0, 0, 0);
    pwm_en = 1'b1;
    tick();
    tick();
    tick();
    check("pre_reset_pwm0", int'(pwm[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pwm", int'(pwm), 0);
    check("midrst_cnt", int'(cnt_o), 0);
    check("midrst_pd", int'(period_done), 0);
    model_reset();
    pwm_en = 1'b0;
    @(negedge chosen_clk);
    rst_n = 1'b1;

    // Degenerate periods: P=0 then P=1
    setup(0, 5, 0, 0, 0);
    pwm_en = 1'b1;
    run(12, h0, h1, h2, h3, pc);
    check("p0_hi", h0, 0);
    check("p0_pd", pc, 0);
    wr_tick(0, 1);
    wr_tick(1, 1);
    run(3, h0, h1, h2, h3, pc);
    run(10, h0, h1, h2, h3, pc);
    check("p1_hi", h0, 10);
    check("p1_pd", pc, 10);

`ifdef PWM_CENTER_ALIGN_EN
    // Centre-aligned: P=4 counts 0,1,2,3,3,2,1,0
    cseq = '{1, 2, 3, 3, 2, 1, 0, 0};
    ctr_mode = 1'b1;
    setup(4, 1, 0, 0, 0);
    pwm_en = 1'b1;
    h0 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("ctr_cnt%0d", i), int'(cnt_o), cseq[i % 8]);
      h0 += int'(pwm[0]);
    end
    check("ctr_hi", h0, 4);
    wr_tick(1, 4);
    wait_pd("ctr_valley");
    run(8, h0, h1, h2, h3, pc);
    check("ctr_full_hi", h0, 8);
    check("ctr_full_pd", pc, 1);
    ctr_mode = 1'b0;
    pwm_en   = 1'b0;
    tick();
`endif

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      pwm_en    = ($urandom_range(0, 99) < 95);
      upd_lock  = ($urandom_range(0, 99) < 20);
      ctr_mode  = 1'($urandom_range(0, 1));
      cfg_we    = ($urandom_range(0, 99) < 25);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_wdata = (cfg_addr == 3'd0) ? CNT_W'($urandom_range(0, 12))
                                     : CNT_W'($urandom_range(0, 14));
      tick();
    end
    cfg_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
